// File: rtl/rom_access_arbiter.sv
// Two-port arbiter in front of a single-port registered program ROM.
// Port A is instruction fetch, port B is the debug/boot loader; each read returns two cycles after its grant.
module rom_access_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              iClk,
    input  logic              iReset,

    input  logic              iReqA,
    input  logic [ADDR_W-1:0] iAddrA,
    output logic              oGntA,
    output logic              oValidA,
    output logic [DATA_W-1:0] oDataA,

    input  logic              iReqB,
    input  logic [ADDR_W-1:0] iAddrB,
    output logic              oGntB,
    output logic              oValidB,
    output logic [DATA_W-1:0] oDataB,

    output logic [ADDR_W-1:0] oRomAddr,
    output logic              oRomEnable,
    input  logic [DATA_W-1:0] iRomData
);

    localparam int              CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    port_e              last_q, last_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               issue_q;
    port_e              tag_q;
    logic               valid_a_q, valid_b_q;
    logic [DATA_W-1:0]  data_a_q, data_b_q;

    logic               gnt_a, gnt_b;
    logic               force_b;

    // B has waited long enough that fixed priority must yield to it.
    assign force_b = (STARVE_LIMIT != 0) && (starve_q >= LIMIT);

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!iReset) begin
            if (iReqA && iReqB) begin
                if (FIXED_PRIO != 0) begin
                    if (force_b) gnt_b = 1'b1;
                    else         gnt_a = 1'b1;
                end else if (last_q == PORT_B) begin
                    gnt_a = 1'b1;
                end else begin
                    gnt_b = 1'b1;
                end
            end else begin
                gnt_a = iReqA;
                gnt_b = iReqB;
            end
        end
    end

    always_comb begin
        last_d   = last_q;
        starve_d = '0;
        if (gnt_a)      last_d = PORT_A;
        else if (gnt_b) last_d = PORT_B;

        if ((FIXED_PRIO != 0) && iReqB && !gnt_b) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            last_q    <= PORT_B;
            starve_q  <= '0;
            issue_q   <= 1'b0;
            tag_q     <= PORT_A;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            starve_q  <= starve_d;
            issue_q   <= gnt_a || gnt_b;
            tag_q     <= gnt_b ? PORT_B : PORT_A;
            valid_a_q <= issue_q && (tag_q == PORT_A);
            valid_b_q <= issue_q && (tag_q == PORT_B);
        end
    end

    // The ROM word is on iRomData during the data phase; only the issuing port's register takes it.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else if (issue_q) begin
            if (tag_q == PORT_A) data_a_q <= iRomData;
            else                 data_b_q <= iRomData;
        end
    end

    assign oGntA      = gnt_a;
    assign oGntB      = gnt_b;
    assign oRomAddr   = gnt_a ? iAddrA : (gnt_b ? iAddrB : '0);
    assign oRomEnable = issue_q;
    assign oValidA    = valid_a_q;
    assign oValidB    = valid_b_q;
    assign oDataA     = data_a_q;
    assign oDataB     = data_b_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Drives a round-robin instance and a fixed-priority (starve limit 3) instance side by side
// and compares both against a cycle-level reference model of the arbitration and read-return rules.
module tb_rom_access_arbiter;

    localparam int MAXC     = 4096;
    localparam int FP_LIMIT = 3;

    logic        clk;
    logic        rst;
    logic        req_a [2];
    logic [7:0]  addr_a [2];
    logic        req_b [2];
    logic [7:0]  addr_b [2];
    logic        gnt_a [2];
    logic        gnt_b [2];
    logic        valid_a [2];
    logic        valid_b [2];
    logic [31:0] data_a [2];
    logic [31:0] data_b [2];
    logic [7:0]  rom_addr [2];
    logic        rom_en [2];
    logic [31:0] rom_q [2];

    // Staged inputs, copied onto the DUT pins at the falling edge.
    logic        s_rst;
    logic        s_req_a [2];
    logic [7:0]  s_addr_a [2];
    logic        s_req_b [2];
    logic [7:0]  s_addr_b [2];

    // Reference model state.
    int          cyc;
    bit          known;
    bit          ptr_b [2];
    int          cnt [2];
    bit          iss_v [2][MAXC];
    bit          iss_b [2][MAXC];
    logic [7:0]  iss_addr [2][MAXC];
    logic [31:0] exp_data [2][2];
    bit          eg_a [2];
    bit          eg_b [2];
    int          n_en [2];
    int          n_va [2];

    int          n_vec;
    int          n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rom_access_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIO(0), .STARVE_LIMIT(16)) u_rr (
        .iClk(clk), .iReset(rst),
        .iReqA(req_a[0]), .iAddrA(addr_a[0]), .oGntA(gnt_a[0]), .oValidA(valid_a[0]), .oDataA(data_a[0]),
        .iReqB(req_b[0]), .iAddrB(addr_b[0]), .oGntB(gnt_b[0]), .oValidB(valid_b[0]), .oDataB(data_b[0]),
        .oRomAddr(rom_addr[0]), .oRomEnable(rom_en[0]), .iRomData(rom_q[0])
    );

    rom_access_arbiter #(.ADDR_W(8), .DATA_W(32), .FIXED_PRIO(1), .STARVE_LIMIT(FP_LIMIT)) u_fp (
        .iClk(clk), .iReset(rst),
        .iReqA(req_a[1]), .iAddrA(addr_a[1]), .oGntA(gnt_a[1]), .oValidA(valid_a[1]), .oDataA(data_a[1]),
        .iReqB(req_b[1]), .iAddrB(addr_b[1]), .oGntB(gnt_b[1]), .oValidB(valid_b[1]), .oDataB(data_b[1]),
        .oRomAddr(rom_addr[1]), .oRomEnable(rom_en[1]), .iRomData(rom_q[1])
    );

    // Registered ROM: word[k] = 0xA5000000 + k.
    always @(posedge clk) begin
        rom_q[0] <= 32'hA500_0000 + {24'h0, rom_addr[0]};
        rom_q[1] <= 32'hA500_0000 + {24'h0, rom_addr[1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_both(input bit ra, input logic [7:0] aa, input bit rb, input logic [7:0] ab);
        for (int m = 0; m < 2; m++) begin
            s_req_a[m]  = ra;
            s_addr_a[m] = aa;
            s_req_b[m]  = rb;
            s_addr_b[m] = ab;
        end
    endtask

    // One clock cycle: apply staged inputs, compare every output with the model, advance the model.
    task automatic tick();
        @(negedge clk);
        rst = s_rst;
        for (int m = 0; m < 2; m++) begin
            req_a[m]  = s_req_a[m];
            addr_a[m] = s_addr_a[m];
            req_b[m]  = s_req_b[m];
            addr_b[m] = s_addr_b[m];
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            string      p;
            bit         ga, gb, en_e, va_e, vb_e;
            logic [7:0] ea;
            p  = (m == 0) ? "rr" : "fp";
            ga = 1'b0;
            gb = 1'b0;
            if (!rst) begin
                if (req_a[m] && req_b[m]) begin
                    if (m == 0) begin
                        ga = ptr_b[m];
                        gb = !ptr_b[m];
                    end else begin
                        gb = (cnt[m] >= FP_LIMIT);
                        ga = !gb;
                    end
                end else begin
                    ga = req_a[m];
                    gb = req_b[m];
                end
            end
            ea = ga ? addr_a[m] : (gb ? addr_b[m] : 8'h00);
            check({p, "_gntA"}, {31'h0, gnt_a[m]}, {31'h0, ga});
            check({p, "_gntB"}, {31'h0, gnt_b[m]}, {31'h0, gb});
            check({p, "_romAddr"}, {24'h0, rom_addr[m]}, {24'h0, ea});

            if (known) begin
                en_e = 1'b0;
                va_e = 1'b0;
                vb_e = 1'b0;
                if (cyc >= 1) en_e = iss_v[m][cyc-1];
                if (cyc >= 2 && iss_v[m][cyc-2]) begin
                    if (iss_b[m][cyc-2]) vb_e = 1'b1;
                    else                 va_e = 1'b1;
                    exp_data[m][iss_b[m][cyc-2]] = 32'hA500_0000 + {24'h0, iss_addr[m][cyc-2]};
                end
                check({p, "_romEnable"}, {31'h0, rom_en[m]}, {31'h0, en_e});
                check({p, "_validA"}, {31'h0, valid_a[m]}, {31'h0, va_e});
                check({p, "_validB"}, {31'h0, valid_b[m]}, {31'h0, vb_e});
                check({p, "_dataA"}, data_a[m], exp_data[m][0]);
                check({p, "_dataB"}, data_b[m], exp_data[m][1]);
            end

            iss_v[m][cyc]    = ga || gb;
            iss_b[m][cyc]    = gb;
            iss_addr[m][cyc] = ea;
            eg_a[m] = ga;
            eg_b[m] = gb;

            if (rst) begin
                ptr_b[m]       = 1'b1;
                cnt[m]         = 0;
                exp_data[m][0] = 32'h0;
                exp_data[m][1] = 32'h0;
                if (cyc >= 1) iss_v[m][cyc-1] = 1'b0;
            end else begin
                if (ga) ptr_b[m] = 1'b0;
                if (gb) ptr_b[m] = 1'b1;
                if (req_b[m] && !gb) cnt[m] = (cnt[m] + 1 > FP_LIMIT) ? FP_LIMIT : cnt[m] + 1;
                else                 cnt[m] = 0;
            end

            if (rom_en[m] === 1'b1)  n_en[m]++;
            if (valid_a[m] === 1'b1) n_va[m]++;
        end
        if (rst) known = 1'b1;
        cyc++;
    endtask

    initial begin
        logic [7:0] gseq [2];
        bit         busy_a [2];
        bit         busy_b [2];

        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        known = 1'b0;
        rst   = 1'b1;
        for (int m = 0; m < 2; m++) begin
            ptr_b[m] = 1'b1;
            cnt[m]   = 0;
            n_en[m]  = 0;
            n_va[m]  = 0;
            busy_a[m] = 1'b0;
            busy_b[m] = 1'b0;
            exp_data[m][0] = 32'h0;
            exp_data[m][1] = 32'h0;
            req_a[m] = 1'b0; addr_a[m] = 8'h0; req_b[m] = 1'b0; addr_b[m] = 8'h0;
        end
        for (int c = 0; c < MAXC; c++) begin
            iss_v[0][c] = 1'b0;
            iss_v[1][c] = 1'b0;
        end

        s_rst = 1'b1;
        set_both(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) tick();
        s_rst = 1'b0;
        repeat (2) tick();

        // Continuous contention straight out of reset.
        set_both(1'b1, 8'h10, 1'b1, 8'h20);
        for (int i = 0; i < 8; i++) begin
            tick();
            gseq[0][i] = gnt_b[0];
            gseq[1][i] = gnt_b[1];
        end
        check("rr_contention_seq", {24'h0, gseq[0]}, 32'h0000_00AA);
        check("fp_contention_seq", {24'h0, gseq[1]}, 32'h0000_0088);
        set_both(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) tick();

        // B drops for one cycle: the starvation count must restart.
        for (int i = 0; i < 8; i++) begin
            set_both(1'b1, 8'h10, (i != 3), 8'h20);
            tick();
            gseq[0][i] = gnt_b[0];
            gseq[1][i] = gnt_b[1];
        end
        check("rr_dropB_seq", {24'h0, gseq[0]}, 32'h0000_0052);
        check("fp_dropB_seq", {24'h0, gseq[1]}, 32'h0000_0080);
        set_both(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) tick();

        // Single A read.
        set_both(1'b1, 8'h05, 1'b0, 8'h00);
        tick();
        set_both(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (2) tick();
        check("rr_single_validA", {31'h0, valid_a[0]}, 32'h1);
        check("rr_single_dataA", data_a[0], 32'hA500_0005);
        check("fp_single_dataA", data_a[1], 32'hA500_0005);
        repeat (2) tick();

        // Burst of eight A reads on consecutive cycles.
        for (int m = 0; m < 2; m++) begin
            n_en[m] = 0;
            n_va[m] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            set_both(1'b1, 8'(i), 1'b0, 8'h00);
            tick();
        end
        set_both(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (4) tick();
        check("rr_burst_valid_count", n_va[0], 8);
        check("rr_burst_enable_count", n_en[0], 8);
        check("fp_burst_valid_count", n_va[1], 8);
        check("rr_burst_last_data", data_a[0], 32'hA500_0007);

        // Reset while a read is in flight.
        set_both(1'b1, 8'h33, 1'b0, 8'h00);
        tick();
        set_both(1'b0, 8'h00, 1'b0, 8'h00);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        set_both(1'b1, 8'h44, 1'b1, 8'h55);
        tick();
        check("rr_rst_validA", {31'h0, valid_a[0]}, 32'h0);
        check("rr_rst_dataA", data_a[0], 32'h0);
        check("rr_rst_romEnable", {31'h0, rom_en[0]}, 32'h0);
        check("rr_rst_first_gntA", {31'h0, gnt_a[0]}, 32'h1);
        check("fp_rst_first_gntA", {31'h0, gnt_a[1]}, 32'h1);
        set_both(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) tick();

        // Randomised traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            s_rst = ($urandom_range(0, 99) == 0);
            for (int m = 0; m < 2; m++) begin
                if (busy_a[m] && $urandom_range(0, 99) < 5) begin
                    busy_a[m] = 1'b0;
                end else if (!busy_a[m] && $urandom_range(0, 99) < 60) begin
                    busy_a[m]   = 1'b1;
                    s_addr_a[m] = 8'($urandom);
                end
                if (busy_b[m] && $urandom_range(0, 99) < 5) begin
                    busy_b[m] = 1'b0;
                end else if (!busy_b[m] && $urandom_range(0, 99) < 60) begin
                    busy_b[m]   = 1'b1;
                    s_addr_b[m] = 8'($urandom);
                end
                s_req_a[m] = busy_a[m];
                s_req_b[m] = busy_b[m];
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                if (eg_a[m]) busy_a[m] = 1'b0;
                if (eg_b[m]) busy_b[m] = 1'b0;
            end
        end
        s_rst = 1'b0;
        set_both(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
